ahb_sram_slave: RTL

//   Synthesizable AHB-Lite responder backed by a word-addressed register array.
//   It is the completion-side counterpart of the ahb_master VIP and serves as the

---
 rtl/ahb_pkg.sv | 24 ++
 rtl/ahb_byte_lane_decode.sv | 36 +++
 rtl/ahb_sram_slave.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings used by the SRAM responder and other bus slaves.
// Holds transfer type, size, response codes and the responder FSM state encoding.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } ahb_state_e;

endpackage

// File: rtl/ahb_byte_lane_decode.sv
// Little-endian byte-lane strobe and alignment check for a 32-bit AHB data bus.
// Unsupported sizes yield an empty strobe; the caller flags them separately.
module ahb_byte_lane_decode
  import ahb_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  output logic [3:0] strb,
  output logic       misalign
);

  // Lane selection and alignment per transfer size.
  always_comb begin
    strb     = 4'b0000;
    misalign = 1'b0;
    case (hsize)
      HSIZE_BYTE: begin
        strb     = 4'b0001 << addr_lo;
        misalign = 1'b0;
      end
      HSIZE_HALF: begin
        strb     = addr_lo[1] ? 4'b1100 : 4'b0011;
        misalign = addr_lo[0];
      end
      HSIZE_WORD: begin
        strb     = 4'b1111;
        misalign = (addr_lo != 2'b00);
      end
      default: begin
        strb     = 4'b0000;
        misalign = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder backed by a word-addressed register array, with
// programmable wait states and a two-cycle ERROR response for illegal accesses.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int unsigned   DW          = 32,
  parameter int unsigned   AW          = 32,
  parameter int unsigned   DEPTH       = 1024,
  parameter logic [AW-1:0] BASE        = {AW{1'b0}},
  parameter int unsigned   WAIT_STATES = 0
) (
  input  logic          hclk,
  input  logic          hreset,
  input  logic          hsel,
  input  logic [AW-1:0] haddr,
  input  logic [1:0]    htrans,
  input  logic [2:0]    hsize,
  input  logic          hwrite,
  input  logic [DW-1:0] hwdata,
  output logic [DW-1:0] hrdata,
  output logic          hready,
  output logic          hresp
);

  localparam int unsigned IW   = $clog2(DEPTH);
  localparam logic [AW:0] SPAN = (AW+1)'(DEPTH) << 2'd2;
  localparam logic [3:0]  WS   = 4'(WAIT_STATES);

  ahb_state_e    state_r;
  logic [3:0]    wait_cnt_r;
  logic          hready_r;
  logic          hresp_r;
  logic          dp_valid_r;
  logic          dp_write_r;
  logic [IW-1:0] dp_index_r;
  logic [3:0]    dp_strb_r;
  logic [DW-1:0] mem_r [DEPTH];

  logic [AW:0]   diff_s;
  logic [3:0]    strb_s;
  logic          misalign_s;
  logic          illegal_s;
  logic          accept_s;
  logic          write_en_s;

  ahb_byte_lane_decode u_lane_decode (
    .hsize    (hsize),
    .addr_lo  (haddr[1:0]),
    .strb     (strb_s),
    .misalign (misalign_s)
  );

  // The extra top bit turns an address below BASE into a huge offset, so one compare covers both bounds.
  assign diff_s     = {1'b0, haddr} - {1'b0, BASE};
  assign illegal_s  = (diff_s >= SPAN) || (hsize > HSIZE_WORD) || misalign_s;
  assign accept_s   = hready_r && hsel && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
  assign write_en_s = !hreset && (state_r == ST_IDLE) && dp_valid_r && dp_write_r;
  assign hready     = hready_r;
  assign hresp      = hresp_r;

  // Address-phase capture, wait/error sequencing and registered handshake outputs.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= 4'd0;
      hready_r   <= 1'b1;
      hresp_r    <= HRESP_OKAY;
      dp_valid_r <= 1'b0;
      dp_write_r <= 1'b0;
      dp_index_r <= {IW{1'b0}};
      dp_strb_r  <= 4'd0;
    end else begin
      case (state_r)
        ST_IDLE, ST_ERR2: begin
          if (accept_s && illegal_s) begin
            state_r    <= ST_ERR1;
            hready_r   <= 1'b0;
            hresp_r    <= HRESP_ERROR;
            dp_valid_r <= 1'b0;
          end else if (accept_s) begin
            dp_valid_r <= 1'b1;
            dp_write_r <= hwrite;
            dp_index_r <= diff_s[IW+1:2];
            dp_strb_r  <= strb_s;
            hresp_r    <= HRESP_OKAY;
            if (WS != 4'd0) begin
              state_r    <= ST_WAIT;
              hready_r   <= 1'b0;
              wait_cnt_r <= WS;
            end else begin
              state_r  <= ST_IDLE;
              hready_r <= 1'b1;
            end
          end else begin
            state_r    <= ST_IDLE;
            hready_r   <= 1'b1;
            hresp_r    <= HRESP_OKAY;
            dp_valid_r <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (wait_cnt_r <= 4'd1) begin
            state_r    <= ST_IDLE;
            hready_r   <= 1'b1;
            wait_cnt_r <= 4'd0;
          end else begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
          end
        end
        ST_ERR1: begin
          state_r  <= ST_ERR2;
          hready_r <= 1'b1;
          hresp_r  <= HRESP_ERROR;
        end
        default: begin
          state_r    <= ST_IDLE;
          wait_cnt_r <= 4'd0;
          hready_r   <= 1'b1;
          hresp_r    <= HRESP_OKAY;
          dp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Byte-lane write at the end of the completing data-phase cycle; the array has no reset.
  always_ff @(posedge hclk) begin
    if (write_en_s) begin
      for (int i = 0; i < 4; i++) begin
        if (dp_strb_r[i]) begin
          mem_r[dp_index_r][i*8 +: 8] <= hwdata[i*8 +: 8];
        end
      end
    end
  end

  // Read mux: the array is read directly so a write completing just before is visible.
  always_comb begin
    if (dp_valid_r && !dp_write_r) begin
      hrdata = mem_r[dp_index_r];
    end else begin
      hrdata = {DW{1'b0}};
    end
  end

endmodule
